// File: rtl/input_handler.sv
// input_handler: byte-serial ASCII frame parser for the host link.
// Frame: ID byte, command byte, hex-nibble payload ('0'..'?').
// Completion is by terminator or a full buffer, or by an explicit length
// header when INPUT_HANDLER_LEN_HEADER_EN is defined.
// Completed frames are held with ready=1 until data_request.
module input_handler #(
    parameter logic [7:0]  ID_BYTE   = 8'h4C,
    parameter logic [7:0]  TERM_BYTE = 8'h0A,
    parameter int unsigned BUF_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_available,
    input  logic [7:0]           byte_in,
    input  logic                 data_request,
    output logic [7:0]           command,
    output logic [15:0]          data_count,
    output logic [BUF_WIDTH-1:0] buffer,
    output logic                 ready,
    output logic [7:0]           debug
);

    localparam int unsigned MAX_NIB = BUF_WIDTH / 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_LEN_HI = 3'd2,
        S_LEN_LO = 3'd3,
        S_DATA   = 3'd4,
        S_READY  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 avail_q;
    logic [7:0]           command_q, command_d;
    logic [15:0]          count_q, count_d;
    logic [BUF_WIDTH-1:0] buffer_q, buffer_d;
    logic                 ready_q, ready_d;
    logic                 ovf_q, ovf_d;
    logic                 bad_q, bad_d;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
    logic [3:0]           len_hi_q, len_hi_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           len_rx;
`endif

    logic        accept;
    logic        is_nib;
    logic [15:0] count_inc;

    assign accept    = byte_available & ~avail_q;
    assign is_nib    = (byte_in[7:4] == 4'h3);
    assign count_inc = count_q + 16'd1;

    // Next-state and datapath decode; everything only moves on an accepted byte
    // except the READY->IDLE release, which is driven by data_request alone.
    always_comb begin
        state_d   = state_q;
        command_d = command_q;
        count_d   = count_q;
        buffer_d  = buffer_q;
        ready_d   = ready_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        len_rx    = {len_hi_q, byte_in[3:0]};
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && byte_in == ID_BYTE) begin
                    buffer_d = '0;
                    count_d  = '0;
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                if (accept) begin
                    command_d = byte_in;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
                    state_d   = S_LEN_HI;
`else
                    state_d   = S_DATA;
`endif
                end
            end
`ifdef INPUT_HANDLER_LEN_HEADER_EN
            S_LEN_HI: begin
                if (accept) begin
                    if (is_nib) begin
                        len_hi_d = byte_in[3:0];
                        state_d  = S_LEN_LO;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (!is_nib) begin
                        bad_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (len_rx == 8'd0) begin
                        len_d   = 8'd0;
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end else if (32'(len_rx) > MAX_NIB) begin
                        len_d   = 8'(MAX_NIB);
                        ovf_d   = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        len_d   = len_rx;
                        state_d = S_DATA;
                    end
                end
            end
`endif
            S_DATA: begin
                if (accept) begin
                    if (is_nib) begin
                        buffer_d = {buffer_q[BUF_WIDTH-5:0], byte_in[3:0]};
                        count_d  = count_inc;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
                        if (count_inc == {8'h00, len_q}) begin
                            ready_d = 1'b1;
                            state_d = S_READY;
                        end
`else
                        if (count_inc == 16'(MAX_NIB)) begin
                            ovf_d   = 1'b1;
                            ready_d = 1'b1;
                            state_d = S_READY;
                        end
`endif
                    end
`ifndef INPUT_HANDLER_LEN_HEADER_EN
                    else if (byte_in == TERM_BYTE) begin
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end
`endif
                    else begin
                        bad_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_READY: begin
                // A request wins over any byte arriving on the same edge.
                if (data_request) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            avail_q   <= 1'b0;
            command_q <= '0;
            count_q   <= '0;
            buffer_q  <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
            len_hi_q  <= '0;
            len_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            avail_q   <= byte_available;
            command_q <= command_d;
            count_q   <= count_d;
            buffer_q  <= buffer_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
`ifdef INPUT_HANDLER_LEN_HEADER_EN
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
`endif
        end
    end

    assign command    = command_q;
    assign data_count = count_q;
    assign buffer     = buffer_q;
    assign ready      = ready_q;
    assign debug      = {3'b000, bad_q, ovf_q, state_q};

endmodule

// File: tb/tb_input_handler.sv
// Directed self-checking bench for input_handler.
// Covers the default build, or the length-header build when
// INPUT_HANDLER_LEN_HEADER_EN is defined.
module tb_input_handler;

    localparam int unsigned BW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          byte_available = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          data_request = 1'b0;
    logic [7:0]    command;
    logic [15:0]   data_count;
    logic [BW-1:0] buffer;
    logic          ready;
    logic [7:0]    debug;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [7:0]  b;
        int unsigned hold;
        logic [2:0]  st;
        logic        rdy;
        logic [15:0] cnt;
        logic [7:0]  cmd;
    } vec_t;

    input_handler #(
        .ID_BYTE   (8'h4C),
        .TERM_BYTE (8'h0A),
        .BUF_WIDTH (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_available (byte_available),
        .byte_in        (byte_in),
        .data_request   (data_request),
        .command        (command),
        .data_count     (data_count),
        .buffer         (buffer),
        .ready          (ready),
        .debug          (debug)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one byte for 'hold' clocks, then drop the strobe for one clock.
    task automatic send(input logic [7:0] b, input int unsigned hold);
        @(negedge clk);
        byte_in        = b;
        byte_available = 1'b1;
        repeat (hold) @(negedge clk);
        byte_available = 1'b0;
        @(negedge clk);
    endtask

    task automatic request();
        @(negedge clk);
        data_request = 1'b1;
        @(negedge clk);
        data_request = 1'b0;
        @(negedge clk);
    endtask

    logic [BW-1:0] exp_buf;
    vec_t          tbl [20];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", BW'(debug), '0);
        chk("rst_ready", BW'(ready), '0);
        chk("rst_count", BW'(data_count), '0);
        chk("rst_buffer", buffer, '0);
        rst = 1'b1;
        @(negedge clk);

`ifndef INPUT_HANDLER_LEN_HEADER_EN
        // Frame 1: 'L','1','0'..'?',LF, two-clock strobes, checked byte by byte.
        tbl[0]  = '{b: 8'h4C, hold: 2, st: 3'd1, rdy: 1'b0, cnt: 16'd0, cmd: 8'h00};
        tbl[1]  = '{b: 8'h31, hold: 2, st: 3'd4, rdy: 1'b0, cnt: 16'd0, cmd: 8'h31};
        for (int i = 0; i < 16; i++)
            tbl[2+i] = '{b: 8'(8'h30 + i), hold: 2, st: 3'd4, rdy: 1'b0, cnt: 16'(i + 1), cmd: 8'h31};
        tbl[18] = '{b: 8'h0A, hold: 2, st: 3'd5, rdy: 1'b1, cnt: 16'd16, cmd: 8'h31};
        for (int i = 0; i < 19; i++) begin
            send(tbl[i].b, tbl[i].hold);
            chk($sformatf("f1_state[%0d]", i), BW'(debug[2:0]), BW'(tbl[i].st));
            chk($sformatf("f1_ready[%0d]", i), BW'(ready), BW'(tbl[i].rdy));
            chk($sformatf("f1_count[%0d]", i), BW'(data_count), BW'(tbl[i].cnt));
            chk($sformatf("f1_cmd[%0d]", i), BW'(command), BW'(tbl[i].cmd));
        end
        chk("f1_buffer", buffer, BW'(64'h0123456789ABCDEF));
        chk("f1_flags", BW'(debug[7:3]), '0);
        request();
        chk("f1_rel_ready", BW'(ready), '0);
        chk("f1_rel_state", BW'(debug[2:0]), '0);
        chk("f1_rel_count", BW'(data_count), BW'(16));
        chk("f1_rel_buffer", buffer, BW'(64'h0123456789ABCDEF));
        chk("f1_rel_cmd", BW'(command), BW'(8'h31));

        // Long strobe counts once; bytes in READY ignored; request beats a byte.
        send(8'h4C, 1);
        send(8'h41, 1);
        send(8'h37, 5);
        chk("long_count", BW'(data_count), BW'(1));
        send(8'h38, 1);
        chk("long_buf", buffer, BW'(8'h78));
        send(8'h0A, 3);
        chk("long_ready", BW'(ready), BW'(1));
        send(8'h39, 1);
        chk("ready_ign_count", BW'(data_count), BW'(2));
        chk("ready_ign_buf", buffer, BW'(8'h78));
        @(negedge clk);
        byte_in        = 8'h4C;
        byte_available = 1'b1;
        data_request   = 1'b1;
        @(negedge clk);
        byte_available = 1'b0;
        data_request   = 1'b0;
        @(negedge clk);
        chk("simul_state", BW'(debug[2:0]), '0);
        chk("simul_ready", BW'(ready), '0);

        // Buffer fill: 70 '5's after 'L','2'.
        send(8'h4C, 1);
        send(8'h32, 1);
        for (int i = 0; i < 64; i++) send(8'h35, 1);
        chk("ovf_ready", BW'(ready), BW'(1));
        chk("ovf_state", BW'(debug[2:0]), BW'(5));
        for (int i = 0; i < 6; i++) send(8'h35, 1);
        exp_buf = {64{4'h5}};
        chk("ovf_count", BW'(data_count), BW'(64));
        chk("ovf_buffer", buffer, exp_buf);
        chk("ovf_flag", BW'(debug[3]), BW'(1));
        request();

        // Bad character aborts with frame data held.
        send(8'h4C, 1);
        send(8'h33, 1);
        send(8'h30, 1);
        send(8'h47, 1);
        chk("bad_debug", BW'(debug), BW'(8'h18));
        chk("bad_ready", BW'(ready), '0);
        chk("bad_count", BW'(data_count), BW'(1));
        chk("bad_cmd", BW'(command), BW'(8'h33));

        // ID byte mid-frame is a command, then a bad char, not a restart.
        send(8'h4C, 1);
        send(8'h4C, 1);
        chk("midid_cmd", BW'(command), BW'(8'h4C));
        chk("midid_state", BW'(debug[2:0]), BW'(4));
        send(8'h4C, 1);
        chk("midid_abort", BW'(debug[2:0]), '0);
`else
        // Length header 0x10 then 16 nibbles; completion without a terminator.
        send(8'h4C, 1);
        send(8'h31, 1);
        send(8'h31, 1);
        chk("lh_state_lo", BW'(debug[2:0]), BW'(3));
        send(8'h30, 1);
        chk("lh_state_data", BW'(debug[2:0]), BW'(4));
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h30 + i), 1);
            chk($sformatf("lh_ready[%0d]", i), BW'(ready), BW'(i == 15));
        end
        chk("lh_count", BW'(data_count), BW'(16));
        chk("lh_buffer", buffer, BW'(64'h0123456789ABCDEF));
        chk("lh_cmd", BW'(command), BW'(8'h31));
        request();
        chk("lh_rel", BW'(ready), '0);

        // Zero length completes straight from the header.
        send(8'h4C, 1);
        send(8'h32, 1);
        send(8'h30, 1);
        send(8'h30, 1);
        chk("lz_ready", BW'(ready), BW'(1));
        chk("lz_count", BW'(data_count), '0);
        request();

        // Oversized length clamps to a full buffer.
        send(8'h4C, 1);
        send(8'h33, 1);
        send(8'h3F, 1);
        send(8'h3F, 1);
        chk("lc_flag", BW'(debug[3]), BW'(1));
        for (int i = 0; i < 64; i++) send(8'h35, 1);
        exp_buf = {64{4'h5}};
        chk("lc_ready", BW'(ready), BW'(1));
        chk("lc_count", BW'(data_count), BW'(64));
        chk("lc_buffer", buffer, exp_buf);
        request();

        // Terminator before the length is reached is a bad char.
        send(8'h4C, 1);
        send(8'h34, 1);
        send(8'h30, 1);
        send(8'h32, 1);
        send(8'h0A, 1);
        chk("lt_debug", BW'(debug), BW'(8'h18));
        chk("lt_ready", BW'(ready), '0);
`endif

        // Asynchronous reset mid-frame clears everything including sticky flags.
        send(8'h4C, 1);
        send(8'h31, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_debug", BW'(debug), '0);
        chk("arst_cmd", BW'(command), '0);
        chk("arst_count", BW'(data_count), '0);
        chk("arst_buffer", buffer, '0);
        chk("arst_ready", BW'(ready), '0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h58, 1);
        chk("arst_nonid", BW'(debug[2:0]), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_handler.md
Name: input_handler

Overview:
- Byte-serial front end for the host link. Parses ASCII frames of the form ID byte, command byte, hex-nibble payload.
- Accumulates the payload into a 256-bit buffer and presents command, buffer and nibble count to the core with a ready/request handshake.
- Sits between the UART receiver and the command/hash engine.

Parameters:
- ID_BYTE, 8'h4C ('L'): frame start byte.
- TERM_BYTE, 8'h0A (LF): payload terminator.
- BUF_WIDTH, 256: payload buffer width in bits; must be a multiple of 4. MAX_NIB = BUF_WIDTH/4 = 64.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_available  in  1  level strobe from the receiver; may stay high for several clocks per byte.
- byte_in  in  8  received byte; stable while byte_available is high.
- data_request  in  1  consumer acknowledge; frees a completed frame.
- command  out  8  raw command byte of the current/last frame.
- data_count  out  16  payload nibbles received.
- buffer  out  BUF_WIDTH  payload; newest nibble in bits [3:0].
- ready  out  1  frame complete and held.
- debug  out  8  status: [2:0] state code, [3] overflow (sticky), [4] bad-char (sticky), [7:5] 0.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; command, data_count, buffer, ready and debug all 0; edge register 0.
- Byte acceptance:
  - avail_q registers byte_available each clock.
  - accept = byte_available & ~avail_q. Exactly one accept per high pulse, whatever its length.
  - Register updates happen on the clock edge where accept is true.
- States and codes: IDLE=0, CMD=1, LEN_HI=2, LEN_LO=3, DATA=4, READY=5.
- IDLE:
  - accept with byte_in==ID_BYTE: clear buffer and data_count, go to CMD.
  - Any other byte is ignored.
- CMD:
  - accept: command<=byte_in (raw, any value).
  - Go to DATA, or to LEN_HI when the optional feature is enabled.
- DATA, on accept:
  - byte_in in 0x30..0x3F: nibble = byte_in[3:0]; buffer <= {buffer[BUF_WIDTH-5:0], nibble}; data_count+1.
  - If data_count reaches MAX_NIB, go to READY and set debug[3].
  - byte_in==TERM_BYTE: go to READY.
  - Any other byte: set debug[4], abort to IDLE. command/buffer/count are held and ready stays 0.
- READY:
  - ready=1 while in READY; it asserts on the same edge the state is entered.
  - All accepted bytes are ignored.
  - data_request sampled high: ready<=0, go to IDLE. command, buffer and data_count hold until the next ID_BYTE.
- Simultaneous accept and data_request in READY: the request is honoured and the byte is dropped.
- data_request outside READY is ignored.
- ID_BYTE seen mid-frame (CMD/DATA) is treated as ordinary data or an error per the rules above, not as a restart.
- debug[3] and debug[4] clear only on reset.

Optional Feature:
- Macro: INPUT_HANDLER_LEN_HEADER_EN.
- When defined:
  - After CMD, two ASCII nibble bytes (0x30..0x3F) give the payload length in nibbles, high nibble first (LEN_HI, then LEN_LO).
  - A non-nibble byte in either state sets debug[4] and aborts to IDLE.
  - Length 0: go straight from LEN_LO to READY.
  - Length > MAX_NIB: clamp to MAX_NIB and set debug[3].
  - DATA completes when data_count equals the length; TERM_BYTE is then not required and is treated as a bad char if it arrives early.
- When undefined: LEN_HI/LEN_LO do not exist; completion is by TERM_BYTE or MAX_NIB.

Test Plan:
- Reset: hold rst low mid-frame -> all outputs 0, state IDLE; after release, a non-'L' byte leaves state IDLE.
- 'L', '1', '0','1',…,'9',':',';','<','=','>','?', LF, each with byte_available high for 2 clocks -> command=0x31, data_count=16, buffer[63:0]=0x0123456789ABCDEF, upper bits 0, ready=1; then data_request pulse -> ready=0, outputs held.
- byte_available held high for 5 clocks on one data byte -> data_count increments by exactly 1.
- 'L','2' then 70 nibbles of '5' -> ready after the 64th nibble, data_count=64, buffer all 5s, debug[3]=1, extra bytes ignored.
- 'L','3','0','G' -> debug[4]=1, state IDLE, ready=0.
- With INPUT_HANDLER_LEN_HEADER_EN: 'L','1','1','0' then 16 nibbles '0'..'?' -> ready on the 16th nibble, data_count=16, buffer[63:0]=0x0123456789ABCDEF.
